// File: rtl/pi_loop_filter_param.sv
// pi_loop_filter_param
//   PI loop filter for the Gardner symbol-timing loop. Takes the signed TED
//   error, runs it through a proportional path and a saturating integral path,
//   and produces the NCO frequency word. Each accepted sample is processed by a
//   four-state sequence (IDLE -> MULT -> ACC -> OUT). fe_valid rises three
//   clocks after the accepting edge.
//
//   Optional feature macro: LOCK_DETECT_EN
//     defined   -> lock detector counts consecutive accepted samples with
//                  |err| < LOCK_THR and asserts lock after LOCK_CNT of them.
//     undefined -> no counter; lock is tied 0.
//
// Ports
//   clk        clock
//   reset      asynchronous active-high reset
//   err_valid  1-cycle qualifier for err
//   err        signed timing error, Q(ERR_W-FRAC_W).FRAC_W
//   kp_in      proportional gain to load, Q1.(GAIN_W-1)
//   ki_in      integral gain to load, Q1.(GAIN_W-1)
//   gain_load  load kp_in/ki_in (deferred to IDLE if a sample is in flight)
//   freeze     hold the integrator; the P path stays active
//   ovr_clr    clear the sticky overrun flag
//   fe         signed filter output; holds between strobes
//   fe_valid   1-cycle strobe, fe updated
//   busy       sample in flight (MULT/ACC/OUT)
//   sat_flag   fe was clipped on this fe_valid
//   overrun    sticky: err_valid arrived while busy
//   lock       lock indication (0 unless LOCK_DETECT_EN)
module pi_loop_filter_param #(
  parameter int ERR_W    = 32,
  parameter int FRAC_W   = 16,
  parameter int GAIN_W   = 16,
  parameter int INT_W    = 40,
  parameter int KP_RST   = 16384,
  parameter int KI_RST   = 1638,
  parameter int LOCK_THR = 4096,
  parameter int LOCK_CNT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     err_valid,
  input  logic signed [ERR_W-1:0]  err,
  input  logic signed [GAIN_W-1:0] kp_in,
  input  logic signed [GAIN_W-1:0] ki_in,
  input  logic                     gain_load,
  input  logic                     freeze,
  input  logic                     ovr_clr,
  output logic signed [ERR_W-1:0]  fe,
  output logic                     fe_valid,
  output logic                     busy,
  output logic                     sat_flag,
  output logic                     overrun,
  output logic                     lock
);

  localparam int PW = ERR_W + GAIN_W;   // proportional product width
  localparam int IW = INT_W + GAIN_W;   // integral product width (>= PW)
  localparam int SW = IW + 1;           // output sum width

  localparam logic signed [SW-1:0] FE_MAX = {{(SW-ERR_W+1){1'b0}}, {(ERR_W-1){1'b1}}};
  localparam logic signed [SW-1:0] FE_MIN = {{(SW-ERR_W+1){1'b1}}, {(ERR_W-1){1'b0}}};

  if (INT_W < ERR_W || FRAC_W >= ERR_W || LOCK_CNT < 1 || LOCK_THR < 1) begin : g_bad_params
    $error("pi_loop_filter_param: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_ACC, S_OUT} state_t;

  state_t                   state_q, state_d;
  logic                     accept;
  logic signed [ERR_W-1:0]  err_q;
  logic signed [INT_W-1:0]  integ_q, integ_d;
  logic signed [INT_W:0]    integ_sum;
  logic signed [PW-1:0]     p_q, p_d, p_sh;
  logic signed [IW-1:0]     i_q, i_d, i_sh;
  logic signed [SW-1:0]     out_sum;
  logic signed [GAIN_W-1:0] kp_q, ki_q, kp_pend_q, ki_pend_q;
  logic                     pend_q;
  logic signed [ERR_W-1:0]  fe_q, fe_d;
  logic                     sat_q, sat_d;
  logic                     fe_valid_q;
  logic                     ovr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: if (err_valid) begin
        state_d = S_MULT;
        accept  = 1'b1;
      end
      S_MULT:  state_d = S_ACC;
      S_ACC:   state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Integrator: one bit of headroom, clamp on signed overflow instead of wrapping.
  always_comb begin
    integ_sum = (INT_W+1)'(integ_q) + (INT_W+1)'(err_q);
    if (integ_sum[INT_W] != integ_sum[INT_W-1])
      integ_d = {integ_sum[INT_W], {(INT_W-1){~integ_sum[INT_W]}}};
    else
      integ_d = integ_sum[INT_W-1:0];
  end

  assign p_d = PW'(kp_q) * PW'(err_q);
  assign i_d = IW'(ki_q) * IW'(integ_q);

  // Arithmetic shifts floor toward -inf; sum is wide enough to never wrap.
  always_comb begin
    p_sh    = p_q >>> (GAIN_W-1);
    i_sh    = i_q >>> (GAIN_W-1);
    out_sum = SW'(p_sh) + SW'(i_sh);
    sat_d   = 1'b1;
    if (out_sum > FE_MAX)      fe_d = {1'b0, {(ERR_W-1){1'b1}}};
    else if (out_sum < FE_MIN) fe_d = {1'b1, {(ERR_W-1){1'b0}}};
    else begin
      fe_d  = out_sum[ERR_W-1:0];
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q      <= '0;
      integ_q    <= '0;
      p_q        <= '0;
      i_q        <= '0;
      fe_q       <= '0;
      sat_q      <= 1'b0;
      fe_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      fe_valid_q <= 1'b0;
      if (accept) err_q <= err;
      case (state_q)
        S_MULT: begin
          if (!freeze) integ_q <= integ_d;
          p_q <= p_d;
        end
        S_ACC: i_q <= i_d;
        S_OUT: begin
          fe_q       <= fe_d;
          sat_q      <= sat_d;
          fe_valid_q <= 1'b1;
        end
        default: ;
      endcase
      // Set has priority over clear.
      if (err_valid && state_q != S_IDLE) ovr_q <= 1'b1;
      else if (ovr_clr)                   ovr_q <= 1'b0;
    end
  end

  // Gains: direct load only when idle and not accepting; otherwise shadowed
  // and committed on the OUT->IDLE edge so the in-flight sample keeps old gains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kp_q      <= GAIN_W'(KP_RST);
      ki_q      <= GAIN_W'(KI_RST);
      kp_pend_q <= '0;
      ki_pend_q <= '0;
      pend_q    <= 1'b0;
    end else if (state_q == S_OUT) begin
      pend_q <= 1'b0;
      if (gain_load) begin
        kp_q <= kp_in;
        ki_q <= ki_in;
      end else if (pend_q) begin
        kp_q <= kp_pend_q;
        ki_q <= ki_pend_q;
      end
    end else if (gain_load) begin
      if (state_q == S_IDLE && !err_valid) begin
        kp_q <= kp_in;
        ki_q <= ki_in;
      end else begin
        kp_pend_q <= kp_in;
        ki_pend_q <= ki_in;
        pend_q    <= 1'b1;
      end
    end
  end

`ifdef LOCK_DETECT_EN
  localparam int CNT_W = $clog2(LOCK_CNT + 1);
  localparam logic signed [ERR_W-1:0] THR = ERR_W'(LOCK_THR);

  logic [CNT_W-1:0] cnt_q;
  logic             lock_q;
  logic             in_thr;

  assign in_thr = (err_q < THR) && (err_q > -THR);

  // Evaluated in OUT so lock changes together with fe_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      lock_q <= 1'b0;
    end else if (state_q == S_OUT) begin
      if (in_thr) begin
        if (cnt_q != CNT_W'(LOCK_CNT)) cnt_q <= cnt_q + 1'b1;
        lock_q <= (cnt_q >= CNT_W'(LOCK_CNT - 1));
      end else begin
        cnt_q  <= '0;
        lock_q <= 1'b0;
      end
    end
  end

  assign lock = lock_q;
`else
  assign lock = 1'b0;
`endif

  assign fe       = fe_q;
  assign fe_valid = fe_valid_q;
  assign sat_flag = sat_q;
  assign overrun  = ovr_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_pi_loop_filter_param.sv
// Directed bench for pi_loop_filter_param with hand-computed expected values.
module tb_pi_loop_filter_param;

  logic               clk = 1'b0;
  logic               reset;
  logic               err_valid;
  logic signed [31:0] err;
  logic signed [15:0] kp_in, ki_in;
  logic               gain_load, freeze, ovr_clr;
  logic signed [31:0] fe;
  logic               fe_valid, busy, sat_flag, overrun, lock;

  int checks = 0;
  int errors = 0;

  pi_loop_filter_param #(
    .ERR_W(32), .FRAC_W(16), .GAIN_W(16), .INT_W(40),
    .KP_RST(16384), .KI_RST(1638), .LOCK_THR(4096), .LOCK_CNT(16)
  ) dut (
    .clk(clk), .reset(reset), .err_valid(err_valid), .err(err),
    .kp_in(kp_in), .ki_in(ki_in), .gain_load(gain_load), .freeze(freeze),
    .ovr_clr(ovr_clr), .fe(fe), .fe_valid(fe_valid), .busy(busy),
    .sat_flag(sat_flag), .overrun(overrun), .lock(lock)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        load;
    logic [15:0] kp;
    logic [15:0] ki;
    logic        frz;
    logic [31:0] e;
    logic [31:0] exp_fe;
    logic        exp_sat;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load_gains(input logic [15:0] nkp, input logic [15:0] nki);
    @(negedge clk);
    kp_in = nkp; ki_in = nki; gain_load = 1'b1;
    @(posedge clk); #1;
    gain_load = 1'b0;
  endtask

  // mode 0: plain; 1: gain_load on the accepting edge; 2: gain_load during MULT
  task automatic do_sample(input logic [31:0] e, input logic frz, input int mode,
                           input logic [15:0] nkp, input logic [15:0] nki,
                           output logic [31:0] fe_o, output logic sat_o,
                           output int lat, output logic busy_o);
    bit got;
    @(negedge clk);
    err = e; freeze = frz; err_valid = 1'b1;
    if (mode == 1) begin gain_load = 1'b1; kp_in = nkp; ki_in = nki; end
    @(posedge clk); #1;
    err_valid = 1'b0; gain_load = 1'b0;
    busy_o = busy;
    if (mode == 2) begin gain_load = 1'b1; kp_in = nkp; ki_in = nki; end
    lat = 0; got = 0;
    while (!got && lat < 8) begin
      @(posedge clk); #1;
      gain_load = 1'b0;
      lat++;
      if (fe_valid) got = 1;
    end
    freeze = 1'b0;
    fe_o = fe; sat_o = sat_flag;
  endtask

  logic [31:0] f;
  logic        s, b;
  int          lat, nv;

  initial begin
    reset = 1'b1; err_valid = 0; err = '0; kp_in = '0; ki_in = '0;
    gain_load = 0; freeze = 0; ovr_clr = 0;

    vt[0] = '{0, 16'h0000, 16'h0000, 0, 32'h0001_0000, 32'h0000_8CCC, 0};
    vt[1] = '{0, 16'h0000, 16'h0000, 0, 32'h0001_0000, 32'h0000_9998, 0};
    vt[2] = '{0, 16'h0000, 16'h0000, 0, 32'hFFFE_0000, 32'hFFFF_0000, 0};
    vt[3] = '{0, 16'h0000, 16'h0000, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0};
    vt[4] = '{0, 16'h0000, 16'h0000, 1, 32'h0001_0000, 32'h0000_7FFF, 0};
    vt[5] = '{1, 16'h8000, 16'h0000, 0, 32'h0001_0000, 32'hFFFF_0000, 0};
    vt[6] = '{1, 16'h0000, 16'h4000, 0, 32'h0000_0001, 32'h0000_8000, 0};
    vt[7] = '{0, 16'h0000, 16'h0000, 0, 32'h0000_0000, 32'h0000_8000, 0};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_fe", fe, 32'h0);
    chk("rst_fe_valid", {31'b0, fe_valid}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_sat", {31'b0, sat_flag}, 32'h0);
    chk("rst_overrun", {31'b0, overrun}, 32'h0);
    chk("rst_lock", {31'b0, lock}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Table: integrator history carries from one vector to the next.
    for (int i = 0; i < 8; i++) begin
      if (vt[i].load) load_gains(vt[i].kp, vt[i].ki);
      do_sample(vt[i].e, vt[i].frz, 0, 16'h0, 16'h0, f, s, lat, b);
      chk($sformatf("vec%0d_fe", i), f, vt[i].exp_fe);
      chk($sformatf("vec%0d_sat", i), {31'b0, s}, {31'b0, vt[i].exp_sat});
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      chk($sformatf("vec%0d_busy", i), {31'b0, b}, 32'h1);
      if (i == 0) begin
        @(posedge clk); #1;
        chk("t1_fe_valid_one_cycle", {31'b0, fe_valid}, 32'h0);
        chk("t1_fe_hold", fe, 32'h0000_8CCC);
      end
    end

    // T4: reset in ACC discards the sample and restores reset gains.
    @(negedge clk);
    err = 32'h0001_0000; err_valid = 1'b1;
    @(posedge clk); #1;
    err_valid = 1'b0;
    @(posedge clk); #1;
    chk("t4_busy_in_acc", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    #1;
    chk("t4_fe", fe, 32'h0);
    chk("t4_busy", {31'b0, busy}, 32'h0);
    chk("t4_fe_valid", {31'b0, fe_valid}, 32'h0);
    nv = 0;
    repeat (3) begin @(posedge clk); #1; if (fe_valid) nv++; end
    @(negedge clk);
    reset = 1'b0;
    repeat (5) begin @(posedge clk); #1; if (fe_valid) nv++; end
    chk("t4_no_strobe", 32'(nv), 32'd0);
    do_sample(32'h0001_0000, 0, 0, 16'h0, 16'h0, f, s, lat, b);
    chk("t4_next_fe", f, 32'h0000_8CCC);

    // T5: gain_load during MULT, then coincident with the accept.
    do_sample(32'h0001_0000, 0, 2, 16'h0, 16'h0, f, s, lat, b);
    chk("t5_a_old_gains", f, 32'h0000_9998);
    do_sample(32'h0001_0000, 0, 0, 16'h0, 16'h0, f, s, lat, b);
    chk("t5_b_zero", f, 32'h0);
    do_sample(32'h0001_0000, 0, 1, 16'd16384, 16'd1638, f, s, lat, b);
    chk("t5_c_coincident_old", f, 32'h0);
    do_sample(32'h0000_0000, 0, 0, 16'h0, 16'h0, f, s, lat, b);
    chk("t5_d_new_gains", f, 32'h0000_3330);

    // T3: back-to-back err_valid -> one strobe, sticky overrun, set beats clear.
    @(negedge clk);
    err = '0; err_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    err_valid = 1'b0;
    nv = 0;
    if (fe_valid) nv++;
    repeat (8) begin @(posedge clk); #1; if (fe_valid) nv++; end
    chk("t3_one_strobe", 32'(nv), 32'd1);
    chk("t3_overrun_set", {31'b0, overrun}, 32'h1);
    @(negedge clk);
    err_valid = 1'b1;
    @(posedge clk); #1;
    ovr_clr = 1'b1;
    @(posedge clk); #1;
    err_valid = 1'b0; ovr_clr = 1'b0;
    chk("t3_set_wins", {31'b0, overrun}, 32'h1);
    repeat (4) @(posedge clk);
    #1;
    chk("t3_sticky", {31'b0, overrun}, 32'h1);
    @(negedge clk); ovr_clr = 1'b1;
    @(negedge clk); ovr_clr = 1'b0;
    chk("t3_cleared", {31'b0, overrun}, 32'h0);

    // T2: full-scale saturation, long enough to pin the integrator.
    do_reset();
    load_gains(16'h7FFF, 16'h7FFF);
    for (int k = 0; k < 300; k++) begin
      do_sample(32'h7FFF_FFFF, 0, 0, 16'h0, 16'h0, f, s, lat, b);
      chk($sformatf("t2_pos_fe_%0d", k), f, 32'h7FFF_FFFF);
      chk($sformatf("t2_pos_sat_%0d", k), {31'b0, s}, 32'h1);
    end
    do_reset();
    load_gains(16'h7FFF, 16'h7FFF);
    for (int k = 0; k < 300; k++) begin
      do_sample(32'h8000_0000, 0, 0, 16'h0, 16'h0, f, s, lat, b);
      chk($sformatf("t2_neg_fe_%0d", k), f, 32'h8000_0000);
      chk($sformatf("t2_neg_sat_%0d", k), {31'b0, s}, 32'h1);
    end

`ifdef LOCK_DETECT_EN
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      do_sample(32'h0000_0800, 0, 0, 16'h0, 16'h0, f, s, lat, b);
      chk($sformatf("t6_lock_%0d", k), {31'b0, lock}, (k == 16) ? 32'h1 : 32'h0);
    end
    do_sample(32'h0001_0000, 0, 0, 16'h0, 16'h0, f, s, lat, b);
    chk("t6_unlock", {31'b0, lock}, 32'h0);
`else
    chk("lock_tied_low", {31'b0, lock}, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
